alarm_unit: RTL and testbench

Alarm stage consuming the running time (hr, min, sec, AM/PM) from the clock core and producing alarm state, a stored alarm time for display and a blinking LED pattern. It sits beside the BCD/seven-segment display path, taking the same 12-hour time values, and is driven by debounced key pulses and switch levels from the board top. The block arms, matches, rings, snoozes (with a bounded snooze count) and times out.

---
 rtl/alarm_pkg.sv | 34 +++
 rtl/alarm_unit_if.sv | 34 +++
 rtl/alarm_unit_time12_add.sv | 33 +++
 rtl/alarm_unit.sv | 153 +++++++++++++++
 tb/tb_alarm_unit.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm stage: FSM states, the 12-hour
// time record and the single-step edit helpers for hour and minute.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_e;

    localparam logic [4:0] HR_MIN  = 5'd1;
    localparam logic [4:0] HR_MAX  = 5'd12;
    localparam logic [5:0] MIN_MAX = 6'd59;

    typedef struct packed {
        logic [4:0] hr;
        logic [5:0] min;
        logic       pm;
    } time12_t;

    localparam time12_t MIDNIGHT = '{hr: HR_MAX, min: 6'd0, pm: 1'b0};

    // Hour step for editing: 12 wraps to 1, AM/PM is left alone.
    function automatic logic [4:0] nextHour(input logic [4:0] hr);
        return (hr == HR_MAX) ? HR_MIN : hr + 5'd1;
    endfunction

    // Minute step for editing: 59 wraps to 0 without touching the hour.
    function automatic logic [5:0] nextMinute(input logic [5:0] min);
        return (min == MIN_MAX) ? 6'd0 : min + 6'd1;
    endfunction

endpackage

// File: rtl/alarm_unit_if.sv
// Bundle of the running time, key/switch controls and alarm outputs.
// The board top (master) drives time and controls; the alarm (slave) answers.
interface alarm_unit_if;

    logic [4:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
    logic       pm;
    logic       arm;
    logic       set_en;
    logic       inc_hr;
    logic       inc_min;
    logic       tog_pm;
    logic       snooze;
    logic       stop;

    logic [4:0] alarm_hr;
    logic [5:0] alarm_min;
    logic       alarm_pm;
    logic       ringing;
    logic [1:0] state;
    logic [9:0] led;

    modport master (
        output hr, min, sec, pm, arm, set_en, inc_hr, inc_min, tog_pm, snooze, stop,
        input  alarm_hr, alarm_min, alarm_pm, ringing, state, led
    );

    modport slave (
        input  hr, min, sec, pm, arm, set_en, inc_hr, inc_min, tog_pm, snooze, stop,
        output alarm_hr, alarm_min, alarm_pm, ringing, state, led
    );

endinterface

// File: rtl/alarm_unit_time12_add.sv
// Combinational 12-hour clock addition of a fixed minute count (1..59),
// carrying into the hour and flipping AM/PM when 11 rolls over to 12.
module time12_add
    import alarm_pkg::*;
#(
    parameter int unsigned ADD_MIN = 5
) (
    input  time12_t t_i,
    output time12_t t_o
);

    logic [6:0] minSum;

    // At most one hour carry since the addend is below an hour.
    always_comb begin
        minSum = {1'b0, t_i.min} + 7'(ADD_MIN);
        t_o    = t_i;
        if (minSum >= 7'd60) begin
            t_o.min = 6'(minSum - 7'd60);
            if (t_i.hr == HR_MAX) begin
                t_o.hr = HR_MIN;
            end else begin
                t_o.hr = t_i.hr + 5'd1;
                if (t_i.hr == HR_MAX - 5'd1) begin
                    t_o.pm = ~t_i.pm;
                end
            end
        end else begin
            t_o.min = minSum[5:0];
        end
    end

endmodule

// File: rtl/alarm_unit.sv
// Alarm stage: stores an editable alarm time, rings when the running time
// reaches it, supports a bounded number of snoozes, times out after a fixed
// number of seconds and blinks the LED bar while ringing.
module alarm_unit
    import alarm_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BLINK_HZ   = 2,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input  logic         clk,
    input  logic         rst,
    alarm_unit_if.slave  bus
);

    localparam int unsigned BLINK_RAW  = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned BLINK_HALF = (BLINK_RAW > 0) ? BLINK_RAW : 1;
    localparam int unsigned BW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned RC_W = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
    localparam int unsigned SC_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [RC_W-1:0] RING_LAST  = RC_W'(RING_SEC - 1);
    localparam logic [SC_W-1:0] SNOOZE_CAP = SC_W'(MAX_SNOOZE);

    state_e          state_q;
    time12_t         alarm_q;
    time12_t         target_q;
    logic [5:0]      secCopy_q;
    logic [RC_W-1:0] ringCnt_q;
    logic [SC_W-1:0] snoozeCnt_q;
    logic [BW-1:0]   blinkCnt_q;
    logic            blinkOn_q;
    logic            led_q;
    logic            ringing_q;

    time12_t nowTime;
    time12_t snoozeSum;
    logic    tick;
    logic    alarmMatch;
    logic    snoozeMatch;

    assign nowTime = '{hr: bus.hr, min: bus.min, pm: bus.pm};

    time12_add #(.ADD_MIN(SNOOZE_MIN)) u_snoozeAdd (
        .t_i (nowTime),
        .t_o (snoozeSum)
    );

    // A second boundary is any cycle where the seconds input moved; matches only fire on it.
    always_comb begin
        tick        = (bus.sec != secCopy_q);
        alarmMatch  = tick && (bus.sec == 6'd0) && (nowTime == alarm_q);
        snoozeMatch = tick && (bus.sec == 6'd0) && (nowTime == target_q);
    end

    // Alarm FSM with alarm-time editing, ring/snooze counters and the blink divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            alarm_q     <= MIDNIGHT;
            target_q    <= MIDNIGHT;
            secCopy_q   <= bus.sec;
            ringCnt_q   <= '0;
            snoozeCnt_q <= '0;
            blinkCnt_q  <= '0;
            blinkOn_q   <= 1'b0;
            led_q       <= 1'b0;
            ringing_q   <= 1'b0;
        end else begin
            secCopy_q <= bus.sec;

            if (bus.set_en && (state_q == IDLE || state_q == ARMED)) begin
                if (bus.inc_hr)  alarm_q.hr  <= nextHour(alarm_q.hr);
                if (bus.inc_min) alarm_q.min <= nextMinute(alarm_q.min);
                if (bus.tog_pm)  alarm_q.pm  <= ~alarm_q.pm;
            end

            ringing_q  <= 1'b0;
            led_q      <= 1'b0;
            blinkCnt_q <= '0;
            blinkOn_q  <= 1'b0;

            if (!bus.arm) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= ARMED;
                    end
                    ARMED: begin
                        if (alarmMatch && !bus.set_en) begin
                            state_q     <= RINGING;
                            ringing_q   <= 1'b1;
                            ringCnt_q   <= '0;
                            snoozeCnt_q <= '0;
                            blinkOn_q   <= 1'b1;
                        end
                    end
                    RINGING: begin
                        if (bus.stop) begin
                            state_q <= ARMED;
                        end else if (bus.snooze) begin
                            if (snoozeCnt_q < SNOOZE_CAP) begin
                                state_q     <= SNOOZE;
                                snoozeCnt_q <= snoozeCnt_q + SC_W'(1);
                                target_q    <= snoozeSum;
                            end else begin
                                state_q <= ARMED;
                            end
                        end else if (tick && ringCnt_q == RING_LAST) begin
                            state_q <= ARMED;
                        end else begin
                            ringing_q <= 1'b1;
                            led_q     <= blinkOn_q;
                            if (tick) ringCnt_q <= ringCnt_q + RC_W'(1);
                            if (blinkCnt_q == BLINK_LAST) begin
                                blinkCnt_q <= '0;
                                blinkOn_q  <= ~blinkOn_q;
                            end else begin
                                blinkCnt_q <= blinkCnt_q + BW'(1);
                                blinkOn_q  <= blinkOn_q;
                            end
                        end
                    end
                    SNOOZE: begin
                        if (bus.stop) begin
                            state_q <= ARMED;
                        end else if (snoozeMatch) begin
                            state_q   <= RINGING;
                            ringing_q <= 1'b1;
                            ringCnt_q <= '0;
                            blinkOn_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.alarm_hr  = alarm_q.hr;
    assign bus.alarm_min = alarm_q.min;
    assign bus.alarm_pm  = alarm_q.pm;
    assign bus.ringing   = ringing_q;
    assign bus.state     = state_q;
    assign bus.led       = {10{led_q}};

endmodule

// File: tb/tb_alarm_unit.sv
// Testbench for alarm_unit: directed scenarios plus a randomized soak,
// all compared against a minutes-of-day reference model.
module tb_alarm_unit;

    localparam int CLK_HZ     = 8;
    localparam int BLINK_HZ   = 2;
    localparam int RING_SEC   = 60;
    localparam int SNOOZE_MIN = 5;
    localparam int MAX_SNOOZE = 3;
    localparam int HALF       = CLK_HZ / (2 * BLINK_HZ);

    localparam int S_IDLE = 0, S_ARMED = 1, S_RINGING = 2, S_SNOOZE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alarm_unit_if bus();

    alarm_unit #(
        .CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ), .RING_SEC(RING_SEC),
        .SNOOZE_MIN(SNOOZE_MIN), .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;
    int nowSec  = 0;

    // Reference model; times are minutes since midnight (0 = 12:00 AM).
    int mState = 0, mAlarm = 0, mTarget = 0, mRing = 0, mSnz = 0, mAge = 0, mPrevSec = 0;

    function automatic int hrOf(input int m);
        int h;
        h = (m % 720) / 60;
        return (h == 0) ? 12 : h;
    endfunction

    function automatic logic [9:0] expLed();
        if (mState == S_RINGING && mAge >= 1 && (((mAge - 1) / HALF) % 2 == 0)) return 10'h3FF;
        return 10'h000;
    endfunction

    task automatic driveTime();
        int h24;
        h24 = nowSec / 3600;
        bus.hr  = 5'((h24 % 12 == 0) ? 12 : h24 % 12);
        bus.min = 6'((nowSec / 60) % 60);
        bus.sec = 6'(nowSec % 60);
        bus.pm  = (h24 >= 12);
    endtask

    task automatic setTime(input int h12, input int m, input int s, input int p);
        nowSec = p * 43200 + (h12 % 12) * 3600 + m * 60 + s;
        driveTime();
    endtask

    // Advance the model on the current inputs, then clock the DUT once and drop pulses.
    task automatic applyStimulus();
        int tick, nowM, nState, h, mm, p;
        bit mA, mT;
        if (rst) begin
            mState = S_IDLE; mAlarm = 0; mTarget = 0; mRing = 0; mSnz = 0; mAge = 0;
        end else begin
            tick   = (int'(bus.sec) != mPrevSec);
            nowM   = int'(bus.pm) * 720 + (int'(bus.hr) % 12) * 60 + int'(bus.min);
            mA     = tick && bus.sec == 0 && nowM == mAlarm;
            mT     = tick && bus.sec == 0 && nowM == mTarget;
            nState = mState;
            if (bus.set_en && (mState == S_IDLE || mState == S_ARMED)) begin
                h  = (mAlarm % 720) / 60;
                mm = mAlarm % 60;
                p  = mAlarm / 720;
                if (bus.inc_hr)  h  = (h + 1) % 12;
                if (bus.inc_min) mm = (mm + 1) % 60;
                if (bus.tog_pm)  p  = 1 - p;
                mAlarm = p * 720 + h * 60 + mm;
            end
            if (!bus.arm) nState = S_IDLE;
            else case (mState)
                S_IDLE:  nState = S_ARMED;
                S_ARMED: if (mA && !bus.set_en) begin nState = S_RINGING; mRing = 0; mSnz = 0; end
                S_RINGING: begin
                    if (bus.stop) nState = S_ARMED;
                    else if (bus.snooze) begin
                        if (mSnz < MAX_SNOOZE) begin
                            nState = S_SNOOZE; mSnz++; mTarget = (nowM + SNOOZE_MIN) % 1440;
                        end else nState = S_ARMED;
                    end else if (tick) begin
                        mRing++;
                        if (mRing == RING_SEC) nState = S_ARMED;
                    end
                end
                default: begin
                    if (bus.stop) nState = S_ARMED;
                    else if (mT) begin nState = S_RINGING; mRing = 0; end
                end
            endcase
            if (nState == S_RINGING) mAge = (mState == S_RINGING) ? mAge + 1 : 0;
            mState = nState;
        end
        mPrevSec = int'(bus.sec);
        @(posedge clk);
        #1;
        bus.inc_hr = 0; bus.inc_min = 0; bus.tog_pm = 0; bus.snooze = 0; bus.stop = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.arm = 1'b1;
        setTime(3, 14, 15, 1);
        applyStimulus();
        applyStimulus();
        nChecks++; if (bus.state !== 2'd0) $display("[TB] FAIL reset_state: got %0d want 0", bus.state); else nPass++;
        nChecks++; if (bus.alarm_hr !== 5'd12) $display("[TB] FAIL reset_hr: got %0d want 12", bus.alarm_hr); else nPass++;
        nChecks++; if (bus.alarm_min !== 6'd0) $display("[TB] FAIL reset_min: got %0d want 0", bus.alarm_min); else nPass++;
        nChecks++; if (bus.alarm_pm !== 1'b0) $display("[TB] FAIL reset_pm: got %0d want 0", bus.alarm_pm); else nPass++;
        nChecks++; if (bus.ringing !== 1'b0) $display("[TB] FAIL reset_ringing: got %0d want 0", bus.ringing); else nPass++;
        nChecks++; if (bus.led !== 10'h000) $display("[TB] FAIL reset_led: got %0h want 0", bus.led); else nPass++;
        rst = 1'b0;
    endtask

    task automatic test_set_alarm();
        applyStimulus();
        nChecks++; if (bus.state !== 2'd1) $display("[TB] FAIL arm_state: got %0d want 1", bus.state); else nPass++;
        bus.set_en = 1'b1;
        repeat (7)  begin bus.inc_hr = 1'b1;  applyStimulus(); end
        repeat (30) begin bus.inc_min = 1'b1; applyStimulus(); end
        bus.set_en = 1'b0;
        applyStimulus();
        nChecks++; if (bus.alarm_hr !== 5'd7) $display("[TB] FAIL set_hr: got %0d want 7", bus.alarm_hr); else nPass++;
        nChecks++; if (bus.alarm_min !== 6'd30) $display("[TB] FAIL set_min: got %0d want 30", bus.alarm_min); else nPass++;
        nChecks++; if (bus.alarm_pm !== 1'b0) $display("[TB] FAIL set_pm: got %0d want 0", bus.alarm_pm); else nPass++;
    endtask

    task automatic test_ring_and_blink();
        logic [9:0] want;
        setTime(7, 29, 59, 0);
        applyStimulus();
        nChecks++; if (bus.ringing !== 1'b0) $display("[TB] FAIL early_ring: got %0d want 0", bus.ringing); else nPass++;
        setTime(7, 30, 0, 0);
        applyStimulus();
        nChecks++; if (bus.ringing !== 1'b1) $display("[TB] FAIL match_ring: got %0d want 1", bus.ringing); else nPass++;
        nChecks++; if (bus.state !== 2'd2) $display("[TB] FAIL match_state: got %0d want 2", bus.state); else nPass++;
        nChecks++; if (bus.led !== 10'h000) $display("[TB] FAIL entry_led: got %0h want 0", bus.led); else nPass++;
        for (int k = 1; k <= 4 * HALF; k++) begin
            applyStimulus();
            want = (((k - 1) / HALF) % 2 == 0) ? 10'h3FF : 10'h000;
            nChecks++; if (bus.led !== want) $display("[TB] FAIL blink_%0d: got %0h want %0h", k, bus.led, want); else nPass++;
        end
    endtask

    task automatic test_timeout();
        for (int t = 1; t <= RING_SEC; t++) begin
            nowSec = nowSec + 1;
            driveTime();
            applyStimulus();
            if (t == RING_SEC - 1) begin
                nChecks++; if (bus.state !== 2'd2) $display("[TB] FAIL pre_timeout: got %0d want 2", bus.state); else nPass++;
            end
            if (t == RING_SEC) begin
                nChecks++; if (bus.state !== 2'd1) $display("[TB] FAIL timeout_state: got %0d want 1", bus.state); else nPass++;
                nChecks++; if (bus.led !== 10'h000) $display("[TB] FAIL timeout_led: got %0h want 0", bus.led); else nPass++;
            end
            applyStimulus();
        end
    endtask

    task automatic test_snooze_wrap();
        bus.set_en = 1'b1;
        repeat (4)  begin bus.inc_hr = 1'b1;  applyStimulus(); end
        repeat (28) begin bus.inc_min = 1'b1; applyStimulus(); end
        bus.tog_pm = 1'b1; applyStimulus();
        bus.set_en = 1'b0;
        nChecks++; if ({bus.alarm_hr, bus.alarm_min, bus.alarm_pm} !== {5'd11, 6'd58, 1'b1})
            $display("[TB] FAIL alarm_1158pm: got %0d:%0d pm=%0d want 11:58 pm=1", bus.alarm_hr, bus.alarm_min, bus.alarm_pm); else nPass++;
        setTime(11, 57, 59, 1); applyStimulus();
        setTime(11, 58, 0, 1);  applyStimulus();
        nChecks++; if (bus.state !== 2'd2) $display("[TB] FAIL ring_1158: got %0d want 2", bus.state); else nPass++;
        bus.snooze = 1'b1; applyStimulus();
        nChecks++; if (bus.state !== 2'd3) $display("[TB] FAIL snooze_state: got %0d want 3", bus.state); else nPass++;
        setTime(12, 2, 59, 0); applyStimulus();
        nChecks++; if (bus.state !== 2'd3) $display("[TB] FAIL snooze_hold: got %0d want 3", bus.state); else nPass++;
        setTime(12, 3, 0, 0); applyStimulus();
        nChecks++; if (bus.ringing !== 1'b1) $display("[TB] FAIL snooze_wrap_ring: got %0d want 1", bus.ringing); else nPass++;
    endtask

    task automatic test_max_snooze();
        for (int i = 1; i <= 2; i++) begin
            bus.snooze = 1'b1; applyStimulus();
            setTime(12, 2 + 5 * i, 59, 0); applyStimulus();
            setTime(12, 3 + 5 * i, 0, 0);  applyStimulus();
            nChecks++; if (bus.state !== 2'd2) $display("[TB] FAIL resnooze_ring_%0d: got %0d want 2", i, bus.state); else nPass++;
        end
        bus.snooze = 1'b1; applyStimulus();
        nChecks++; if (bus.state !== 2'd1) $display("[TB] FAIL fourth_snooze: got %0d want 1", bus.state); else nPass++;
    endtask

    task automatic test_back_to_back();
        setTime(11, 57, 59, 1); applyStimulus();
        setTime(11, 58, 0, 1);  applyStimulus();
        nChecks++; if (bus.state !== 2'd2) $display("[TB] FAIL b2b_ring: got %0d want 2", bus.state); else nPass++;
        bus.stop = 1'b1; bus.snooze = 1'b1; applyStimulus();
        nChecks++; if (bus.state !== 2'd1) $display("[TB] FAIL stop_wins: got %0d want 1", bus.state); else nPass++;
        setTime(11, 57, 59, 1); applyStimulus();
        setTime(11, 58, 0, 1);  applyStimulus();
        bus.snooze = 1'b1; applyStimulus();
        nChecks++; if (bus.state !== 2'd3) $display("[TB] FAIL b2b_snooze: got %0d want 3", bus.state); else nPass++;
        bus.arm = 1'b0; applyStimulus();
        nChecks++; if (bus.state !== 2'd0) $display("[TB] FAIL disarm: got %0d want 0", bus.state); else nPass++;
        bus.arm = 1'b1; applyStimulus();
        setTime(12, 2, 59, 0); applyStimulus();
        setTime(12, 3, 0, 0);  applyStimulus();
        nChecks++; if (bus.state !== 2'd1) $display("[TB] FAIL no_ring_after_disarm: got %0d want 1", bus.state); else nPass++;
    endtask

    task automatic test_edit();
        bus.set_en = 1'b1;
        bus.inc_min = 1'b1; applyStimulus();
        bus.inc_min = 1'b1; applyStimulus();
        nChecks++; if ({bus.alarm_hr, bus.alarm_min, bus.alarm_pm} !== {5'd11, 6'd0, 1'b1})
            $display("[TB] FAIL min_wrap: got %0d:%0d pm=%0d want 11:0 pm=1", bus.alarm_hr, bus.alarm_min, bus.alarm_pm); else nPass++;
        bus.inc_hr = 1'b1; applyStimulus();
        nChecks++; if ({bus.alarm_hr, bus.alarm_pm} !== {5'd12, 1'b1}) $display("[TB] FAIL hr_11_12: got %0d pm=%0d want 12 pm=1", bus.alarm_hr, bus.alarm_pm); else nPass++;
        bus.inc_hr = 1'b1; applyStimulus();
        nChecks++; if (bus.alarm_hr !== 5'd1) $display("[TB] FAIL hr_wrap: got %0d want 1", bus.alarm_hr); else nPass++;
        bus.inc_hr = 1'b1; bus.inc_min = 1'b1; bus.tog_pm = 1'b1; applyStimulus();
        nChecks++; if ({bus.alarm_hr, bus.alarm_min, bus.alarm_pm} !== {5'd2, 6'd1, 1'b0})
            $display("[TB] FAIL edit_all: got %0d:%0d pm=%0d want 2:1 pm=0", bus.alarm_hr, bus.alarm_min, bus.alarm_pm); else nPass++;
        setTime(2, 0, 59, 0); applyStimulus();
        setTime(2, 1, 0, 0);  applyStimulus();
        nChecks++; if (bus.state !== 2'd1) $display("[TB] FAIL edit_blocks_ring: got %0d want 1", bus.state); else nPass++;
        bus.set_en = 1'b0;
        setTime(2, 0, 59, 0); applyStimulus();
        setTime(2, 1, 0, 0);  applyStimulus();
        nChecks++; if (bus.state !== 2'd2) $display("[TB] FAIL edit_ring: got %0d want 2", bus.state); else nPass++;
        bus.set_en = 1'b1; bus.inc_hr = 1'b1; bus.inc_min = 1'b1; bus.tog_pm = 1'b1; applyStimulus();
        nChecks++; if ({bus.alarm_hr, bus.alarm_min, bus.alarm_pm} !== {5'd2, 6'd1, 1'b0})
            $display("[TB] FAIL edit_in_ring: got %0d:%0d pm=%0d want 2:1 pm=0", bus.alarm_hr, bus.alarm_min, bus.alarm_pm); else nPass++;
        bus.stop = 1'b1; applyStimulus();
        bus.set_en = 1'b0;
    endtask

    task automatic test_random();
        int u;
        for (int c = 0; c < 4000; c++) begin
            u = $urandom_range(0, 999);
            if (u < 5) bus.arm = 1'b0; else if (u < 40) bus.arm = 1'b1;
            if ($urandom_range(0, 99) == 0) bus.set_en = ~bus.set_en;
            bus.inc_hr  = ($urandom_range(0, 19) == 0);
            bus.inc_min = ($urandom_range(0, 19) == 0);
            bus.tog_pm  = ($urandom_range(0, 39) == 0);
            bus.snooze  = ($urandom_range(0, 29) == 0);
            bus.stop    = ($urandom_range(0, 59) == 0);
            u = $urandom_range(0, 99);
            if (u < 30)       nowSec = (nowSec + 1) % 86400;
            else if (u == 30) nowSec = (mAlarm * 60 + 86399) % 86400;
            else if (u == 31) nowSec = (mTarget * 60 + 86399) % 86400;
            driveTime();
            applyStimulus();
            nChecks++; if (bus.state !== 2'(mState)) $display("[TB] FAIL rnd_state@%0d: got %0d want %0d", c, bus.state, mState); else nPass++;
            nChecks++; if (bus.ringing !== (mState == S_RINGING)) $display("[TB] FAIL rnd_ringing@%0d: got %0d", c, bus.ringing); else nPass++;
            nChecks++; if (bus.led !== expLed()) $display("[TB] FAIL rnd_led@%0d: got %0h want %0h", c, bus.led, expLed()); else nPass++;
            nChecks++; if (bus.alarm_hr !== 5'(hrOf(mAlarm))) $display("[TB] FAIL rnd_hr@%0d: got %0d want %0d", c, bus.alarm_hr, hrOf(mAlarm)); else nPass++;
            nChecks++; if (bus.alarm_min !== 6'(mAlarm % 60)) $display("[TB] FAIL rnd_min@%0d: got %0d want %0d", c, bus.alarm_min, mAlarm % 60); else nPass++;
            nChecks++; if (bus.alarm_pm !== (mAlarm >= 720)) $display("[TB] FAIL rnd_pm@%0d: got %0d", c, bus.alarm_pm); else nPass++;
        end
    endtask

    // Scenario sequence followed by the summary.
    initial begin
        bus.arm = 1'b0; bus.set_en = 1'b0; bus.inc_hr = 1'b0; bus.inc_min = 1'b0;
        bus.tog_pm = 1'b0; bus.snooze = 1'b0; bus.stop = 1'b0;
        setTime(3, 14, 15, 1);
        test_reset();
        test_set_alarm();
        test_ring_and_blink();
        test_timeout();
        test_snooze_wrap();
        test_max_snooze();
        test_back_to_back();
        test_edit();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
